itc_b04: RTL and testbench



---
 rtl/itc_b04_pkg.sv | 11 +
 rtl/itc_b04_if.sv | 23 ++
 rtl/itc_b04_avg.sv | 32 +++
 rtl/itc_b04.sv | 121 ++++++++++++
 tb/tb_itc_b04.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/itc_b04_pkg.sv
// Shared types and constants for the itc_b04 stream monitor.
package b04_pkg;
   localparam int W = 8;
   localparam int SCAN_LEN = 2 + 8 * W;

   typedef enum logic [1:0] {
      SA = 2'b00,
      SB = 2'b01,
      SC = 2'b10
   } state_e;
endpackage

// File: rtl/itc_b04_if.sv
// Functional and scan signals of itc_b04; master drives, slave is the monitor.
interface itc_b04_if;
   import b04_pkg::*;

   logic         RESTART;
   logic         AVERAGE;
   logic         ENABLE;
   logic [W-1:0] DATA_IN;
   logic [W-1:0] DATA_OUT;
   logic         test_se;
   logic         test_si;
   logic         test_so;

   modport master (
      output RESTART, AVERAGE, ENABLE, DATA_IN, test_se, test_si,
      input  DATA_OUT, test_so
   );

   modport slave (
      input  RESTART, AVERAGE, ENABLE, DATA_IN, test_se, test_si,
      output DATA_OUT, test_so
   );
endinterface

// File: rtl/itc_b04_avg.sv
// Min/max midpoint and 4-sample window average; B04_ROUND_EN selects round-half-up.
module b04_avg
   import b04_pkg::*;
(
   input  logic [W-1:0] rmax,
   input  logic [W-1:0] rmin,
   input  logic [W-1:0] reg1,
   input  logic [W-1:0] reg2,
   input  logic [W-1:0] reg3,
   input  logic [W-1:0] reg4,
   output logic [W-1:0] mid,
   output logic [W-1:0] wavg
);
`ifdef B04_ROUND_EN
   localparam logic [W+1:0] MID_BIAS  = (W+2)'(1);
   localparam logic [W+2:0] WAVG_BIAS = (W+3)'(2);
`else
   localparam logic [W+1:0] MID_BIAS  = '0;
   localparam logic [W+2:0] WAVG_BIAS = '0;
`endif

   logic [W+1:0] mid_sum;
   logic [W+2:0] wavg_sum;

   // One spare bit over the nominal sum width keeps the rounding bias from overflowing.
   assign mid_sum  = {{2{rmax[W-1]}}, rmax} + {{2{rmin[W-1]}}, rmin} + MID_BIAS;
   assign wavg_sum = {{3{reg1[W-1]}}, reg1} + {{3{reg2[W-1]}}, reg2}
                   + {{3{reg3[W-1]}}, reg3} + {{3{reg4[W-1]}}, reg4} + WAVG_BIAS;

   assign mid  = mid_sum[W:1];
   assign wavg = wavg_sum[W+1:2];
endmodule

// File: rtl/itc_b04.sv
// ITC'99 b04 signed stream monitor with a full 66-flop scan chain (option: B04_ROUND_EN).
//  state | meaning
//  SA    | idle after reset, advance to load
//  SB    | load first sample into RMAX/RMIN, clear window
//  SC    | run: track min/max/window, emit selected result
module itc_b04
   import b04_pkg::*;
(
   input  logic       CLOCK,
   input  logic       RESET,
   itc_b04_if.slave   bus
);
   state_e       state_q, state_d;
   logic [W-1:0] rmax_q, rmin_q, rlast_q, reg1_q, reg2_q, reg3_q, reg4_q, dout_q;
   logic [W-1:0] rmax_d, rmin_d, rlast_d, reg1_d, reg2_d, reg3_d, reg4_d, dout_d;
   logic [W-1:0] mid, wavg;
   logic [1:0]   state_raw;
   logic signed [W-1:0] din, rmax_s, rmin_s;
   logic [SCAN_LEN-1:0] chain, shifted;

   assign din    = bus.DATA_IN;
   assign rmax_s = rmax_q;
   assign rmin_s = rmin_q;

   assign chain   = {state_q, rmax_q, rmin_q, rlast_q, reg1_q, reg2_q, reg3_q, reg4_q, dout_q};
   assign shifted = {chain[SCAN_LEN-2:0], bus.test_si};

   b04_avg u_avg (
      .rmax (rmax_q),
      .rmin (rmin_q),
      .reg1 (reg1_q),
      .reg2 (reg2_q),
      .reg3 (reg3_q),
      .reg4 (reg4_q),
      .mid  (mid),
      .wavg (wavg)
   );

   always_comb begin
      state_d   = state_q;
      state_raw = state_q;
      rmax_d    = rmax_q;
      rmin_d    = rmin_q;
      rlast_d   = rlast_q;
      reg1_d    = reg1_q;
      reg2_d    = reg2_q;
      reg3_d    = reg3_q;
      reg4_d    = reg4_q;
      dout_d    = dout_q;
      if (bus.test_se) begin
         {state_raw, rmax_d, rmin_d, rlast_d, reg1_d, reg2_d, reg3_d, reg4_d, dout_d} = shifted;
         state_d = state_e'(state_raw);
      end else begin
         case (state_q)
            SA: state_d = SB;
            SB: begin
               rmax_d  = din;
               rmin_d  = din;
               rlast_d = '0;
               reg1_d  = '0;
               reg2_d  = '0;
               reg3_d  = '0;
               reg4_d  = '0;
               dout_d  = '0;
               state_d = SC;
            end
            SC: begin
               if (bus.RESTART) begin
                  dout_d = bus.AVERAGE ? mid : rlast_q;
                  rmax_d = din;
                  rmin_d = din;
                  reg1_d = '0;
                  reg2_d = '0;
                  reg3_d = '0;
                  reg4_d = '0;
                  if (bus.ENABLE) rlast_d = din;
               end else if (bus.ENABLE) begin
                  dout_d  = bus.AVERAGE ? wavg : rmax_q;
                  rlast_d = din;
                  reg4_d  = reg3_q;
                  reg3_d  = reg2_q;
                  reg2_d  = reg1_q;
                  reg1_d  = din;
                  if (din > rmax_s)      rmax_d = din;
                  else if (din < rmin_s) rmin_d = din;
               end else begin
                  dout_d = bus.AVERAGE ? mid : rlast_q;
               end
            end
            default: state_d = SA;
         endcase
      end
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_q <= SA;
         rmax_q  <= '0;
         rmin_q  <= '0;
         rlast_q <= '0;
         reg1_q  <= '0;
         reg2_q  <= '0;
         reg3_q  <= '0;
         reg4_q  <= '0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         rmax_q  <= rmax_d;
         rmin_q  <= rmin_d;
         rlast_q <= rlast_d;
         reg1_q  <= reg1_d;
         reg2_q  <= reg2_d;
         reg3_q  <= reg3_d;
         reg4_q  <= reg4_d;
         dout_q  <= dout_d;
      end
   end

   assign bus.DATA_OUT = dout_q;
   assign bus.test_so  = state_q[1];
endmodule

// File: tb/tb_itc_b04.sv
// Directed self-checking bench for itc_b04 (functional path, rounding option, scan chain).
module tb_itc_b04;
   logic       clk = 1'b0;
   logic       rst;
   int         n_checks = 0;
   int         n_pass = 0;
   logic [7:0] exp_v;

   itc_b04_if bus ();

   itc_b04 dut (
      .CLOCK (clk),
      .RESET (rst),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic rs, input logic av, input logic en, input logic [7:0] d);
      bus.RESTART = rs;
      bus.AVERAGE = av;
      bus.ENABLE  = en;
      bus.DATA_IN = d;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.test_se = 1'b0;
      bus.test_si = 1'b0;
      set_in(1'b0, 1'b0, 1'b0, 8'd0);
      tick();
      n_checks++;
      if (bus.DATA_OUT !== 8'd0) $display("FAIL reset_dout: got %h want 00", bus.DATA_OUT);
      else n_pass++;
      n_checks++;
      if (dut.state_q !== 2'b00) $display("FAIL reset_state: got %b want 00", dut.state_q);
      else n_pass++;
      n_checks++;
      if (bus.test_so !== 1'b0) $display("FAIL reset_so: got %b want 0", bus.test_so);
      else n_pass++;
      rst = 1'b0;
   endtask

   task automatic test_load();
      set_in(1'b0, 1'b0, 1'b0, 8'd10);
      tick();
      n_checks++;
      if (dut.state_q !== 2'b01) $display("FAIL load_sb: got %b want 01", dut.state_q);
      else n_pass++;
      tick();
      n_checks++;
      if (dut.state_q !== 2'b10) $display("FAIL load_sc: got %b want 10", dut.state_q);
      else n_pass++;
      n_checks++;
      if (bus.DATA_OUT !== 8'd0) $display("FAIL load_dout: got %h want 00", bus.DATA_OUT);
      else n_pass++;
      n_checks++;
      if (dut.rmax_q !== 8'd10 || dut.rmin_q !== 8'd10)
         $display("FAIL load_minmax: got max %0d min %0d want 10 10",
                  $signed(dut.rmax_q), $signed(dut.rmin_q));
      else n_pass++;
   endtask

   task automatic test_minmax();
      logic [7:0] samples [4];
      logic [7:0] outs [4];
      samples = '{8'd20, 8'hFA, 8'd4, 8'd30};
      outs    = '{8'd10, 8'd20, 8'd20, 8'd20};
      for (int i = 0; i < 4; i++) begin
         set_in(1'b0, 1'b0, 1'b1, samples[i]);
         tick();
         n_checks++;
         if (bus.DATA_OUT !== outs[i])
            $display("FAIL minmax_dout%0d: got %0d want %0d", i, $signed(bus.DATA_OUT), $signed(outs[i]));
         else n_pass++;
      end
      n_checks++;
      if (dut.rmax_q !== 8'd30 || dut.rmin_q !== 8'hFA)
         $display("FAIL minmax_regs: got max %0d min %0d want 30 -6",
                  $signed(dut.rmax_q), $signed(dut.rmin_q));
      else n_pass++;
   endtask

   task automatic test_window();
      // window 30,4,-6,20 -> 48/4 = 12
      set_in(1'b0, 1'b1, 1'b1, 8'd30);
      tick();
      n_checks++;
      if (bus.DATA_OUT !== 8'd12) $display("FAIL window_avg: got %0d want 12", $signed(bus.DATA_OUT));
      else n_pass++;
      set_in(1'b0, 1'b0, 1'b1, 8'd30);
      tick();
      n_checks++;
      if (bus.DATA_OUT !== 8'd30) $display("FAIL window_rmax: got %0d want 30", $signed(bus.DATA_OUT));
      else n_pass++;
   endtask

   task automatic test_midpoint();
      set_in(1'b1, 1'b1, 1'b0, 8'd5);
      tick();
      n_checks++;
      if (bus.DATA_OUT !== 8'd12) $display("FAIL restart_mid: got %0d want 12", $signed(bus.DATA_OUT));
      else n_pass++;
      set_in(1'b0, 1'b0, 1'b0, 8'd99);
      tick();
      n_checks++;
      if (bus.DATA_OUT !== 8'd30) $display("FAIL idle_rlast: got %0d want 30", $signed(bus.DATA_OUT));
      else n_pass++;
      set_in(1'b0, 1'b1, 1'b0, 8'd99);
      tick();
      n_checks++;
      if (bus.DATA_OUT !== 8'd5) $display("FAIL idle_mid: got %0d want 5", $signed(bus.DATA_OUT));
      else n_pass++;
      n_checks++;
      if (dut.reg1_q !== 8'd0 || dut.reg4_q !== 8'd0)
         $display("FAIL restart_clear: got reg1 %0d reg4 %0d want 0 0", dut.reg1_q, dut.reg4_q);
      else n_pass++;
      // restart with enable: output uses the old RLAST, new sample captured
      set_in(1'b1, 1'b0, 1'b1, 8'd7);
      tick();
      n_checks++;
      if (bus.DATA_OUT !== 8'd30) $display("FAIL restart_en_old: got %0d want 30", $signed(bus.DATA_OUT));
      else n_pass++;
      set_in(1'b0, 1'b0, 1'b0, 8'd0);
      tick();
      n_checks++;
      if (bus.DATA_OUT !== 8'd7) $display("FAIL restart_en_new: got %0d want 7", $signed(bus.DATA_OUT));
      else n_pass++;
   endtask

   task automatic test_negative();
      set_in(1'b1, 1'b0, 1'b0, 8'h80);
      tick();
      set_in(1'b0, 1'b0, 1'b1, 8'h81);
      tick();
      n_checks++;
      if (bus.DATA_OUT !== 8'h80) $display("FAIL neg_rmax_old: got %0d want -128", $signed(bus.DATA_OUT));
      else n_pass++;
      set_in(1'b0, 1'b1, 1'b0, 8'd0);
      tick();
`ifdef B04_ROUND_EN
      exp_v = 8'h81;
`else
      exp_v = 8'h80;
`endif
      n_checks++;
      if (bus.DATA_OUT !== exp_v)
         $display("FAIL neg_mid: got %0d want %0d", $signed(bus.DATA_OUT), $signed(exp_v));
      else n_pass++;
      // window -127,0,0,0 -> -31.75 truncates to -32; rounded -31.25 also floors to -32
      set_in(1'b0, 1'b1, 1'b1, 8'h81);
      tick();
      exp_v = 8'hE0;
      n_checks++;
      if (bus.DATA_OUT !== exp_v)
         $display("FAIL neg_wavg: got %0d want %0d", $signed(bus.DATA_OUT), $signed(exp_v));
      else n_pass++;
   endtask

   task automatic test_reset_midrun();
      set_in(1'b0, 1'b0, 1'b1, 8'd99);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++;
      if (bus.DATA_OUT !== 8'd0 || dut.state_q !== 2'b00 || dut.rlast_q !== 8'd0)
         $display("FAIL reset_midrun: got dout %h state %b rlast %h want 00 00 00",
                  bus.DATA_OUT, dut.state_q, dut.rlast_q);
      else n_pass++;
   endtask

   task automatic test_scan();
      int   errs;
      logic want;
      rst = 1'b1;
      set_in(1'b0, 1'b0, 1'b0, 8'd0);
      tick();
      rst = 1'b0;
      bus.test_se = 1'b1;
      errs = 0;
      for (int n = 1; n <= 132; n++) begin
         bus.test_si = (n <= 66);
         tick();
         want = (n >= 66 && n <= 131);
         if (bus.test_so !== want) begin
            errs++;
            if (errs < 4) $display("FAIL scan_so edge %0d: got %b want %b", n, bus.test_so, want);
         end
         if (n == 66) begin
            n_checks++;
            if (bus.DATA_OUT !== 8'hFF || dut.state_q !== 2'b11)
               $display("FAIL scan_fill: got dout %h state %b want ff 11", bus.DATA_OUT, dut.state_q);
            else n_pass++;
         end
      end
      n_checks++;
      if (errs != 0) $display("FAIL scan_stream: got %0d bad edges want 0", errs);
      else n_pass++;
      bus.test_si = 1'b1;
      for (int n = 0; n < 66; n++) tick();
      bus.test_se = 1'b0;
      tick();
      n_checks++;
      if (dut.state_q !== 2'b00) $display("FAIL scan_illegal: got %b want 00", dut.state_q);
      else n_pass++;
      bus.test_se = 1'b1;
      bus.test_si = 1'b1;
      for (int n = 0; n < 10; n++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++;
      if (bus.DATA_OUT !== 8'd0 || dut.state_q !== 2'b00 || dut.rmax_q !== 8'd0)
         $display("FAIL scan_reset: got dout %h state %b rmax %h want 00 00 00",
                  bus.DATA_OUT, dut.state_q, dut.rmax_q);
      else n_pass++;
      bus.test_si = 1'b0;
      errs = 0;
      for (int n = 0; n < 66; n++) begin
         if (bus.test_so !== 1'b0) errs++;
         tick();
      end
      n_checks++;
      if (errs != 0) $display("FAIL scan_zero_out: got %0d ones want 0", errs);
      else n_pass++;
      bus.test_se = 1'b0;
   endtask

   initial begin
      test_reset();
      test_load();
      test_minmax();
      test_window();
      test_midpoint();
      test_negative();
      test_reset_midrun();
      test_scan();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
